// File: rtl/rom_ram_boot_loader_if.sv
// rom_ram_boot_loader_if: ROM, RAM port A, CPU and control signals of the boot loader.
interface rom_ram_boot_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic start;
    logic busy;
    logic done;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data;
    logic cpu_wren;
    logic [DATA_W-1:0] cpu_q;
    logic cpu_ready;
    modport slave (
        input start, rom_q, ram_q, cpu_address, cpu_data, cpu_wren,
        output busy, done, rom_address, ram_address, ram_data, ram_wren, cpu_q, cpu_ready
    );
    modport master (
        output start, rom_q, ram_q, cpu_address, cpu_data, cpu_wren,
        input busy, done, rom_address, ram_address, ram_data, ram_wren, cpu_q, cpu_ready
    );
endinterface

// File: rtl/rom_ram_boot_loader.sv
// rom_ram_boot_loader: copies a ROM block into RAM port A after reset or start, then hands port A to the CPU.
module rom_ram_boot_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int COPY_WORDS = 4096,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 0,
    parameter int ROM_LATENCY = 2
) (
    input logic clock,
    input logic reset,
    rom_ram_boot_loader_if.slave bus
);
    localparam int CW = COPY_WORDS > 0 ? $clog2(COPY_WORDS + 1) : 1;
    localparam int L = ROM_LATENCY;
    typedef enum logic [1:0] {COPY, DRAIN, DONE} state_t;
    state_t state;
    logic finished;
    logic [CW-1:0] i, w;
    logic [L-1:0] valid;
    logic [ADDR_W-1:0] dst [L];
    logic wr;
    assign wr = valid[L-1];
    always_ff @(posedge clock) begin
        if (reset || (state == DONE && bus.start)) begin
            state <= COPY;
            finished <= 1'b0;
            i <= '0;
            w <= '0;
            valid <= '0;
        end else begin
            for (int k = L - 1; k > 0; k--) begin
                valid[k] <= valid[k-1];
                dst[k] <= dst[k-1];
            end
            valid[0] <= state == COPY && COPY_WORDS != 0;
            dst[0] <= ADDR_W'(DST_BASE) + ADDR_W'(i);
            if (wr) w <= w + CW'(1);
            if (state == COPY && COPY_WORDS == 0) begin
                state <= DONE;
                finished <= 1'b1;
            end else if (state == COPY) begin
                i <= i + CW'(1);
                if (i == CW'(COPY_WORDS - 1)) state <= DRAIN;
            end else if (state == DRAIN && wr && w == CW'(COPY_WORDS - 1)) begin
                state <= DONE;
                finished <= 1'b1;
            end
        end
    end
    assign bus.rom_address = ADDR_W'(SRC_BASE) + ADDR_W'(i);
    // Once finished, port A is a zero-latency pass-through, so a CPU write in the start cycle still lands.
    assign bus.ram_wren = finished ? bus.cpu_wren : wr & ~reset;
    assign bus.ram_address = finished ? bus.cpu_address : dst[L-1];
    assign bus.ram_data = finished ? bus.cpu_data : DATA_W'(bus.rom_q);
    assign bus.cpu_q = bus.ram_q;
    assign bus.cpu_ready = finished;
    assign bus.done = finished;
    assign bus.busy = ~finished;
endmodule

// File: tb/tb_rom_ram_boot_loader.sv
// tb_rom_ram_boot_loader: vector table, directed corner sequences and random traffic against a cycle-timing model.
module tb_rom_ram_boot_loader;
    localparam int N = 8, L = 2, SRC = 0, DST = 'h100;
    logic clock = 1'b0, rst = 1'b1, rst_aux = 1'b1;
    always #5 clock = ~clock;

    rom_ram_boot_loader_if #(16, 16) mb();
    rom_ram_boot_loader_if #(16, 16) zb();
    rom_ram_boot_loader_if #(16, 16) wb();

    rom_ram_boot_loader #(.ADDR_W(16), .DATA_W(16), .COPY_WORDS(N), .SRC_BASE(SRC), .DST_BASE(DST),
        .ROM_LATENCY(L)) dut (.clock(clock), .reset(rst), .bus(mb));
    rom_ram_boot_loader #(.ADDR_W(16), .DATA_W(16), .COPY_WORDS(0), .SRC_BASE(0), .DST_BASE(0),
        .ROM_LATENCY(2)) zdut (.clock(clock), .reset(rst_aux), .bus(zb));
    rom_ram_boot_loader #(.ADDR_W(16), .DATA_W(16), .COPY_WORDS(4), .SRC_BASE('hFFFE), .DST_BASE('hFFFD),
        .ROM_LATENCY(1)) wdut (.clock(clock), .reset(rst_aux), .bus(wb));

    // main ROM (latency 2) and RAM port A (1-cycle read) models
    logic [15:0] rom_base = 16'hA000;
    logic [15:0] ra1, ra2, wa1;
    logic [15:0] ram [65536];
    logic [15:0] mem_exp [65536];
    always @(posedge clock) begin
        ra1 <= mb.rom_address;
        ra2 <= ra1;
        if (mb.ram_wren) ram[mb.ram_address] <= mb.ram_data;
        mb.ram_q <= ram[mb.ram_address];
        wa1 <= wb.rom_address;
    end
    assign mb.rom_q = rom_base + ra2;
    assign zb.rom_q = 16'hE000;
    assign zb.ram_q = '0;
    assign zb.start = 1'b0;
    assign zb.cpu_wren = 1'b0;
    assign zb.cpu_address = '0;
    assign zb.cpu_data = '0;
    assign wb.rom_q = 16'hD000 + wa1;
    assign wb.ram_q = '0;
    assign wb.start = 1'b0;
    assign wb.cpu_wren = 1'b0;
    assign wb.cpu_address = '0;
    assign wb.cpu_data = '0;

    // observers for the zero-length and wrapping instances
    typedef struct { int c; logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t wq[$];
    int acyc = 0, w_done_cyc = -1;
    logic z_done1 = 1'b0, z_wr = 1'b0;
    always @(negedge clock) begin
        if (rst_aux) acyc = 0;
        else begin
            if (acyc == 1) z_done1 = zb.done;
            z_wr = z_wr | zb.ram_wren;
            if (wb.ram_wren) wq.push_back('{acyc, wb.ram_address, wb.ram_data});
            if (wb.done && w_done_cyc < 0) w_done_cyc = acyc;
            acyc++;
        end
    end

    int errors = 0, checks = 0;
    int cyc = 0, t0 = 0, dut_cw = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: copy starts at t0; word k issued at t0+k, written at t0+k+L; done from t0+N+L.
    task automatic settle();
        int rel;
        logic ed, w;
        #1;
        rel = cyc - t0;
        ed = rel >= N + L;
        chk("done", mb.done, ed);
        chk("busy", mb.busy, !ed);
        chk("cpu_ready", mb.cpu_ready, ed);
        chk("cpu_q", mb.cpu_q, mb.ram_q);
        if (ed) begin
            chk("pass_wren", mb.ram_wren, mb.cpu_wren);
            if (mb.cpu_wren) begin
                chk("pass_addr", mb.ram_address, mb.cpu_address);
                chk("pass_data", mb.ram_data, mb.cpu_data);
            end
        end else begin
            w = !rst && rel >= L;
            chk("copy_wren", mb.ram_wren, w);
            if (w) begin
                chk("copy_addr", mb.ram_address, 16'(DST + rel - L));
                chk("copy_data", mb.ram_data, 16'(rom_base + SRC + rel - L));
            end
            if (!rst && rel < N) chk("rom_address", mb.rom_address, 16'(SRC + rel));
        end
    endtask

    task automatic adv();
        int rel;
        logic ed;
        rel = cyc - t0;
        ed = rel >= N + L;
        if (ed && mb.cpu_wren) mem_exp[mb.cpu_address] = mb.cpu_data;
        else if (!ed && !rst && rel >= L) mem_exp[16'(DST + rel - L)] = 16'(rom_base + SRC + rel - L);
        if (!ed && mb.ram_wren) dut_cw++;
        if (rst || (ed && mb.start)) t0 = cyc + 1;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic rand_cpu(input bit en);
        mb.cpu_wren = en && $urandom_range(0, 1) == 1;
        mb.cpu_address = 16'($urandom_range('h0F0, 'h21F));
        mb.cpu_data = 16'($urandom);
    endtask

    typedef struct {
        logic wren; logic [15:0] addr; logic [15:0] data;
        logic ewren; logic [15:0] eaddr; logic [15:0] edata; logic edone;
    } vec_t;
    vec_t tv[12];
    logic [15:0] wa_exp[4];
    logic [15:0] wd_exp[4];

    initial begin
        int n, mism;
        tv[0]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tv[1]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tv[2]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0100, 16'hA000, 1'b0};
        tv[3]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0101, 16'hA001, 1'b0};
        tv[4]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0102, 16'hA002, 1'b0};
        tv[5]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0103, 16'hA003, 1'b0};
        tv[6]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0104, 16'hA004, 1'b0};
        tv[7]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0105, 16'hA005, 1'b0};
        tv[8]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0106, 16'hA006, 1'b0};
        tv[9]  = '{1'b1, 16'h0105, 16'hFFFF, 1'b1, 16'h0107, 16'hA007, 1'b0};
        tv[10] = '{1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tv[11] = '{1'b1, 16'h0200, 16'h1234, 1'b1, 16'h0200, 16'h1234, 1'b1};
        wa_exp = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
        wd_exp = '{16'hCFFE, 16'hCFFF, 16'hD000, 16'hD001};
        for (int k = 0; k < 65536; k++) begin
            ram[k] = '0;
            mem_exp[k] = '0;
        end
        mb.start = 1'b0;
        mb.cpu_wren = 1'b0;
        mb.cpu_address = '0;
        mb.cpu_data = '0;
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        rst_aux = 1'b0;
        // boot copy with CPU write held on, then CPU write in DONE
        for (int c = 0; c < 12; c++) begin
            mb.cpu_wren = tv[c].wren;
            mb.cpu_address = tv[c].addr;
            mb.cpu_data = tv[c].data;
            settle();
            chk("tv_wren", mb.ram_wren, tv[c].ewren);
            if (tv[c].ewren) begin
                chk("tv_addr", mb.ram_address, tv[c].eaddr);
                chk("tv_data", mb.ram_data, tv[c].edata);
            end
            chk("tv_done", mb.done, tv[c].edone);
            if (c == 10) chk("ram_105", ram[16'h0105], 16'hA005);
            adv();
        end
        mb.cpu_wren = 1'b0;
        settle();
        adv();
        settle();
        chk("cpu_readback", mb.cpu_q, 16'h1234);
        adv();
        for (int k = 0; k < N; k++) chk("boot_image", ram[16'h0100 + k], 16'hA000 + 16'(k));
        // start in DONE, second start mid-copy must be ignored
        rom_base = 16'hB000;
        dut_cw = 0;
        mb.start = 1'b1;
        settle();
        adv();
        mb.start = 1'b0;
        settle();
        chk("done_fall", mb.done, 1'b0);
        adv();
        for (int c = 1; c < 12; c++) begin
            rand_cpu(c < 10);
            mb.start = c == 4;
            settle();
            adv();
        end
        mb.start = 1'b0;
        mb.cpu_wren = 1'b0;
        chk("one_copy", dut_cw, N);
        for (int k = 0; k < N; k++) chk("restart_image", ram[16'h0100 + k], 16'hB000 + 16'(k));
        // reset in the middle of a copy
        rom_base = 16'hC000;
        mb.start = 1'b1;
        settle();
        adv();
        mb.start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rand_cpu(1'b1);
            settle();
            adv();
        end
        rst = 1'b1;
        rand_cpu(1'b1);
        settle();
        chk("rst_wren", mb.ram_wren, 1'b0);
        adv();
        rst = 1'b0;
        mb.cpu_wren = 1'b0;
        settle();
        chk("restart_rom", mb.rom_address, 16'(SRC));
        n = 0;
        while (!mb.done && n < 30) begin
            adv();
            settle();
            n++;
        end
        chk("done_latency", n, N + L);
        adv();
        for (int k = 0; k < N; k++) chk("reset_image", ram[16'h0100 + k], 16'hC000 + 16'(k));
        // random CPU traffic, starts and resets
        for (int c = 0; c < 400; c++) begin
            rand_cpu(1'b1);
            mb.start = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 99) == 0;
            if (mb.start) rom_base = 16'($urandom);
            settle();
            adv();
        end
        rst = 1'b0;
        mb.start = 1'b0;
        mb.cpu_wren = 1'b0;
        repeat (N + L + 2) begin
            settle();
            adv();
        end
        mism = 0;
        for (int k = 0; k < 65536; k++) if (ram[k] !== mem_exp[k]) mism++;
        chk("ram_image", mism, 0);
        // zero-length and wrapping instances
        chk("zero_done_c1", z_done1, 1'b1);
        chk("zero_no_wren", z_wr, 1'b0);
        chk("wrap_count", wq.size(), 4);
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            chk("wrap_addr", wq[k].a, wa_exp[k]);
            chk("wrap_data", wq[k].d, wd_exp[k]);
            chk("wrap_cycle", wq[k].c, k + 1);
        end
        chk("wrap_done", w_done_cyc, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_ram_boot_loader.md
Name: rom_ram_boot_loader

Overview:
- Boot-time sequencer that owns RAM port A (the CPU-side port of the shared CPU/VGA dual-port RAM).
- Out of reset, it copies a block of ROM words into RAM, for example an initial frame buffer or a program image. After the copy it hands port A to the CPU through a pass-through mux.
- Software can re-run the copy with `start`.
- Sits in the `clock_cpu` domain, between the ROM, RAM port A and the CPU core. RAM port B (VGA) is untouched.

Parameters:
- `ADDR_W`, 16, address width of the ROM and of RAM port A.
- `DATA_W`, 16, data width.
- `COPY_WORDS`, 4096, number of words per copy; 0 is legal.
- `SRC_BASE`, 0, first ROM address read.
- `DST_BASE`, 0, first RAM address written.
- `ROM_LATENCY`, 2, cycles from `rom_address` driven to matching `rom_q` valid; minimum 1.

Ports:
- `clock` in 1 CPU-domain clock (PLL c0).
- `reset` in 1 synchronous, active-high reset.
- `start` in 1 single-cycle request to re-run the copy.
- `busy` out 1 high while a copy is in progress.
- `done` out 1 high once the copy has completed and the CPU owns port A.
- `rom_address` out `ADDR_W` ROM read address.
- `rom_q` in `DATA_W` ROM read data.
- `ram_address` out `ADDR_W` RAM port A address.
- `ram_data` out `DATA_W` RAM port A write data.
- `ram_wren` out 1 RAM port A write enable.
- `ram_q` in `DATA_W` RAM port A read data.
- `cpu_address` in `ADDR_W` CPU request address.
- `cpu_data` in `DATA_W` CPU write data.
- `cpu_wren` in 1 CPU write enable.
- `cpu_q` out `DATA_W` CPU read data; equals `ram_q`.
- `cpu_ready` out 1 port A is granted to the CPU; equals `done`.

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high. All state updates on the posedge of `clock`.
- States: COPY, DRAIN, DONE.
- Reset values:
  - State = COPY.
  - Issue counter `i` = 0; write counter `w` = 0; latency pipeline valid bits = 0.
  - `busy` = 1, `done` = 0, `cpu_ready` = 0, `ram_wren` = 0, `rom_address` = `SRC_BASE`.
- Copy starts automatically on the first cycle after `reset` deasserts. No `start` is needed at boot.
- COPY:
  - Each cycle drive `rom_address` = `SRC_BASE` + `i` (mod 2^`ADDR_W`).
  - Push (valid=1, dst = `DST_BASE` + `i` mod 2^`ADDR_W`) into a `ROM_LATENCY`-deep shift pipeline.
  - `i` increments by 1.
  - When `i` reaches `COPY_WORDS` (the last issue this cycle), go to DRAIN.
  - If `COPY_WORDS` = 0, go directly to DONE the cycle after reset; no writes occur.
- Write side, active in COPY and DRAIN: when the pipeline output is valid, in that cycle:
  - `ram_wren` = 1, `ram_address` = pipelined dst, `ram_data` = `rom_q` (combinational from `rom_q`).
  - `w` increments by 1.
- DRAIN: no new issues; pushes are valid=0. When `w` reaches `COPY_WORDS`, go to DONE.
- Timing: issue k happens at cycle k after reset release and is written at cycle k + `ROM_LATENCY`. `done` rises at cycle `COPY_WORDS` + `ROM_LATENCY`.
- DONE:
  - `ram_address` = `cpu_address`, `ram_data` = `cpu_data`, `ram_wren` = `cpu_wren`; all combinational pass-through, zero added latency.
  - `busy` = 0, `done` = 1, `cpu_ready` = 1.
- In COPY and DRAIN:
  - `cpu_wren` is ignored and never reaches RAM.
  - `cpu_ready` = 0.
  - `cpu_q` still mirrors `ram_q`, but is not meaningful.
- `start`:
  - Sampled only in DONE. On `start`=1: clear `i`, `w` and the pipeline, go to COPY, and drop `done` the next cycle.
  - If `cpu_wren`=1 in that same cycle, that CPU write still completes, because the pass-through is combinational in DONE.
  - `start` in COPY or DRAIN is ignored; it is not queued.
- Reset mid-copy:
  - Abort immediately; no `ram_wren` in the reset cycle.
  - Restart from word 0 after release.
  - Words already written remain in RAM and are overwritten by the new pass.
- Address wrap: source and destination addresses wrap modulo 2^`ADDR_W`. Counters are wide enough to hold `COPY_WORDS` with no overflow.
- `busy` = ~`done` at all times.

Test Plan:
1. `COPY_WORDS`=8, `SRC_BASE`=0, `DST_BASE`=0x100, `ROM_LATENCY`=2, ROM model returns 0xA000+addr. Release reset at cycle 0. Required:
   - `ram_wren` high at cycles 2..9 only.
   - Writes 0xA000..0xA007 to 0x100..0x107.
   - `done`=1 from cycle 10.
2. In DONE, CPU writes 0x1234 to 0x0200, then reads it. Required:
   - `ram_wren`/`ram_address`/`ram_data` mirror the CPU inputs in the same cycle.
   - `cpu_q`=0x1234 after RAM read latency.
3. `cpu_wren`=1 held throughout COPY/DRAIN, with `cpu_address`=0x105 and `cpu_data`=0xFFFF. Required: no CPU write reaches RAM; RAM[0x105]=0xA005 at done.
4. Reset asserted at cycle 5 of a copy for 1 cycle. Required: no write in the reset cycle; the copy restarts at ROM address 0; all 8 words are correct at completion; `done` rises 10 cycles after release.
5. `start` pulsed in DONE (with ROM data changed to 0xB000+addr), then `start` pulsed again mid-copy. Required:
   - `done` falls the next cycle.
   - The second pulse is ignored.
   - RAM ends holding 0xB000..0xB007 after exactly one copy.
6. `COPY_WORDS`=0. Required: `done`=1 on the first cycle after reset release; `ram_wren` is never asserted by the loader.
7. `SRC_BASE`=0xFFFE, `DST_BASE`=0xFFFD, `COPY_WORDS`=4. Required: reads from 0xFFFE, 0xFFFF, 0x0000, 0x0001 are written to 0xFFFD, 0xFFFE, 0xFFFF, 0x0000.
